// File: rtl/coherence_snoop_responder.sv
// Snoop responder: looks up the local L1 block status for a bus snoop, flushes Modified data,
// commands the MESI state change and acknowledges the bus. Define SNOOP_STATS_EN for saturating counters.
module coherence_snoop_responder #(
    parameter int N_SETS  = 16,
    parameter int IDX_LSB = 3,
    parameter int STAT_W  = 16
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      snoop_req,
    input  logic [31:0]               snoop_addr,
    input  logic                      snoop_rdx,
    output logic                      snoop_ack,
    output logic                      snoop_hit,
    output logic                      snoop_dirty,
    output logic                      flush_req,
    input  logic                      flush_done,
    output logic [$clog2(N_SETS)-1:0] set_sel,
    input  logic                      valid,
    input  logic                      exclusive,
    input  logic                      dirty,
    output logic [1:0]                state_transfer,
    output logic                      cc_update
`ifdef SNOOP_STATS_EN
    ,
    output logic [STAT_W-1:0]         stat_hits,
    output logic [STAT_W-1:0]         stat_flushes,
    output logic [STAT_W-1:0]         stat_invals
`endif
);

    localparam int SET_W = $clog2(N_SETS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FLUSH,
        S_UPDATE,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        CC_INVALID   = 2'd0,
        CC_SHARED    = 2'd1,
        CC_EXCLUSIVE = 2'd2,
        CC_MODIFIED  = 2'd3
    } cc_end_state_t;

    state_t        state;
    logic          rdx_q;
    logic          dirty_q;
    cc_end_state_t target_q;
    cc_end_state_t lookup_target;

    // Any block we keep a copy of drops to Shared on a read, Invalid on a read-exclusive.
    assign lookup_target = rdx_q ? CC_INVALID : CC_SHARED;

    // Only the set-index field of the snooped address selects anything in this cache.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{snoop_addr[31:IDX_LSB+SET_W], snoop_addr[IDX_LSB-1:0]};

    // NOTE: every register here uses non-blocking assignment so all state updates
    // take effect together at the clock edge regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state          <= S_IDLE;
            rdx_q          <= 1'b0;
            dirty_q        <= 1'b0;
            target_q       <= CC_INVALID;
            set_sel        <= '0;
            snoop_ack      <= 1'b0;
            snoop_hit      <= 1'b0;
            snoop_dirty    <= 1'b0;
            flush_req      <= 1'b0;
            cc_update      <= 1'b0;
            state_transfer <= CC_INVALID;
        end else begin
            snoop_ack   <= 1'b0;
            snoop_hit   <= 1'b0;
            snoop_dirty <= 1'b0;
            cc_update   <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (snoop_req) begin
                        rdx_q   <= snoop_rdx;
                        set_sel <= snoop_addr[IDX_LSB +: SET_W];
                        state   <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    target_q <= lookup_target;
                    dirty_q  <= 1'b0;
                    if (!valid) begin
                        snoop_ack <= 1'b1;
                        state     <= S_RESP;
                    end else if (dirty) begin
                        dirty_q   <= 1'b1;
                        flush_req <= 1'b1;
                        state     <= S_FLUSH;
                    end else if (exclusive || rdx_q) begin
                        cc_update      <= 1'b1;
                        state_transfer <= lookup_target;
                        state          <= S_UPDATE;
                    end else begin
                        // Shared copy on a shared read: nothing to change locally.
                        snoop_ack <= 1'b1;
                        snoop_hit <= 1'b1;
                        state     <= S_RESP;
                    end
                end

                S_FLUSH: begin
                    if (flush_done) begin
                        flush_req      <= 1'b0;
                        cc_update      <= 1'b1;
                        state_transfer <= target_q;
                        state          <= S_UPDATE;
                    end
                end

                S_UPDATE: begin
                    snoop_ack   <= 1'b1;
                    snoop_hit   <= 1'b1;
                    snoop_dirty <= dirty_q;
                    state       <= S_RESP;
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SNOOP_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_hits    <= '0;
            stat_flushes <= '0;
            stat_invals  <= '0;
        end else begin
            if (snoop_ack && snoop_hit && (stat_hits != '1))
                stat_hits <= stat_hits + STAT_W'(1);
            if (snoop_ack && snoop_dirty && (stat_flushes != '1))
                stat_flushes <= stat_flushes + STAT_W'(1);
            if (cc_update && (state_transfer == CC_INVALID) && (stat_invals != '1))
                stat_invals <= stat_invals + STAT_W'(1);
        end
    end
`else
    localparam int unused_stat_w = STAT_W;
`endif

endmodule

// File: doc/coherence_snoop_responder.md
Name: coherence_snoop_responder

Overview:
- Coherency-unit end of the cache coherence interface, one per L1 cache.
- Accepts snoop requests from the coherence bus.
- Drives set_sel into the local cache, samples the block status (valid/exclusive/dirty) and decides the MESI response.
- Requests a flush for Modified blocks, then commands the state change via state_transfer with an update strobe, and acknowledges the bus.

Parameters:
- N_SETS, 16, number of cache sets; set_sel width = $clog2(N_SETS).
- IDX_LSB, 3, address bit where the set index starts (2 byte-offset bits + 1 word-offset bit for BLOCK_SIZE 2).
- STAT_W, 16, width of the statistics counters (optional feature only).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- snoop_req  input  1  bus snoop request; held high until snoop_ack.
- snoop_addr  input  32  snooped byte address; latched on acceptance.
- snoop_rdx  input  1  1 = read-exclusive/invalidate, 0 = shared read.
- snoop_ack  output  1  one-cycle response strobe.
- snoop_hit  output  1  local cache held the block; valid with snoop_ack.
- snoop_dirty  output  1  block was Modified and was flushed; valid with snoop_ack.
- flush_req  output  1  request to bus/cache to write back the block; held until flush_done.
- flush_done  input  1  flush complete.
- set_sel  output  $clog2(N_SETS)  set index to cache.
- valid  input  1  cache status: block present for the snooped address.
- exclusive  input  1  cache status: exclusive.
- dirty  input  1  cache status: dirty.
- state_transfer  output  2  cc_end_state target state for the cache.
- cc_update  output  1  one-cycle strobe; cache applies state_transfer to set_sel.

Behaviour:
- Reset: all outputs 0; state_transfer = INVALID; FSM = IDLE.
- Reset is asynchronous at any point. An in-progress snoop is abandoned, flush_req drops immediately, and no ack is issued.
- IDLE: if snoop_req, latch snoop_rdx and set_sel <= snoop_addr[IDX_LSB +: $clog2(N_SETS)], then go to LOOKUP.
- LOOKUP (1 cycle): cache status is combinational from set_sel. Sample it and classify:
  - dirty → M
  - exclusive & !dirty → E
  - valid & !exclusive → S
  - !valid → I (dirty/exclusive ignored when !valid)
- Transitions out of LOOKUP:
  - I → RESP, hit=0.
  - S & !rdx → RESP, hit=1, no update.
  - S & rdx → UPDATE with target INVALID.
  - E → UPDATE with target SHARED (!rdx) or INVALID (rdx).
  - M → FLUSH; target SHARED (!rdx) or INVALID (rdx); snoop_dirty=1.
- FLUSH: flush_req=1. flush_done is sampled from the first FLUSH cycle onward. On flush_done: flush_req deasserts at the next edge, go to UPDATE. No timeout.
- UPDATE (1 cycle): cc_update=1, state_transfer=target, set_sel held. Then go to RESP.
- RESP (1 cycle): snoop_ack=1 with snoop_hit and snoop_dirty. Then go to IDLE.
- snoop_hit/snoop_dirty are 0 whenever snoop_ack is 0.
- Latency, counting the acceptance edge as cycle 0, with snoop_ack high in:
  - Miss, or S shared read: cycle 2.
  - Clean hit needing an update: cycle 3.
  - M hit: cycle 3+F, where F = number of FLUSH cycles.
- snoop_req while busy: not accepted; requester keeps it high.
- A new request is accepted no earlier than the cycle after snoop_ack. snoop_req still high in the ack cycle is not a new request.
- snoop_addr/snoop_rdx changes after acceptance are ignored.
- flush_done outside FLUSH is ignored.
- set_sel holds its last value in IDLE.
- state_transfer holds its last target; the cache uses it only when cc_update=1.

Optional Feature:
- Macro: SNOOP_STATS_EN.
- When defined, adds three outputs, each STAT_W bits, reset 0, saturating at all-ones:
  - stat_hits: +1 per ack with hit.
  - stat_flushes: +1 per ack with dirty.
  - stat_invals: +1 per cc_update with target INVALID.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Miss: valid=0, addr 0x0000_0048, rdx=0 → set_sel=9; ack at cycle 2 with hit=0, dirty=0; cc_update never asserted.
- E shared read: addr 0x38, valid=1, exclusive=1, dirty=0, rdx=0 → set_sel=7; cc_update at cycle 2 with state_transfer=SHARED; ack at cycle 3 with hit=1, dirty=0.
- M read-exclusive: valid=1, exclusive=1, dirty=1, rdx=1, flush_done 4 cycles after flush_req rises → flush_req high for exactly 4 cycles; then cc_update with INVALID; ack with hit=1, dirty=1.
- S paths: valid=1, exclusive=0. rdx=0 → ack at cycle 2, no update. rdx=1 → update INVALID, ack at cycle 3. Back-to-back with snoop_req held → second snoop is accepted only after the first ack.
- Reset mid-flush: assert nRST low during FLUSH → flush_req/cc_update/snoop_ack go to 0 asynchronously, state_transfer=INVALID. After release, a miss snoop completes normally at cycle 2.
- SNOOP_STATS_EN, STAT_W=2: 5 M read-exclusive snoops → stat_hits=3, stat_flushes=3, stat_invals=3 (saturated).
